fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL set the first fetch address after reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 resetn  input  1  SHALL be the reset: synchronous and active-low.
REQ-004 hazard_stall  input  1  SHALL indicate a load-use hazard stall from decode.
REQ-005 exe_stall  input  1  SHALL indicate a multi-cycle execute stall.
REQ-006 jmp  input  1  SHALL indicate a taken branch or jump redirect.
REQ-007 jmp_target  input  32  SHALL carry the redirect address, with bits [1:0] ignored and forced to 00.
REQ-008 imem_req  output  1  SHALL be the instruction-memory request.
REQ-009 imem_addr  output  32  SHALL be the word-aligned fetch address.
REQ-010 imem_ack  input  1  SHALL indicate that imem_rdata is valid this cycle.
REQ-011 imem_rdata  input  32  SHALL carry the instruction word.
REQ-012 pc  output  32  SHALL carry the PC of the presented instruction, feeding the IF/ID register.
REQ-013 inst  output  32  SHALL carry the presented instruction, feeding the IF/ID register.
REQ-014 inst_valid  output  1  SHALL be 1 when pc/inst hold a real instruction and 0 for a bubble.

Function
REQ-015 stall SHALL be defined as hazard_stall | exe_stall; priority SHALL be resetn > jmp > stall.
REQ-016 FSM states SHALL be IDLE, WAIT, HOLD and DROP, encoded in 2 bits; unused encodings SHALL go to IDLE.
REQ-017 IDLE SHALL drive imem_req=0 and go to WAIT on the next non-reset cycle.
REQ-018 WAIT and DROP SHALL drive imem_req=1; imem_addr SHALL remain stable from request until the ack cycle.
REQ-019 WAIT with imem_ack=1, jmp=0 and stall=0 SHALL present the instruction:
- pc <= fetch_pc, inst <= imem_rdata, inst_valid <= 1;
- fetch_pc <= fetch_pc+4;
- stay in WAIT, so back-to-back requests give throughput of 1 instruction per ack.
REQ-020 WAIT with imem_ack=1, jmp=0 and stall=1 SHALL latch imem_rdata and fetch_pc into a one-entry buffer and go to HOLD.
REQ-021 HOLD SHALL drive imem_req=0; when stall falls it SHALL present the buffer, advance fetch_pc by 4 and return to WAIT.
REQ-022 jmp in WAIT with imem_ack=1, or in HOLD, SHALL discard the data, set fetch_pc <= {jmp_target[31:2],2'b00} and go to WAIT.
REQ-023 jmp in WAIT with imem_ack=0 SHALL latch the target into redirect_pc and go to DROP.
REQ-024 DROP SHALL keep the old request until ack, discard the returned data, load fetch_pc <= redirect_pc and go to WAIT.
REQ-025 A further jmp while in DROP SHALL overwrite redirect_pc; jmp simultaneous with the DROP ack SHALL use the new target.
REQ-026 pc/inst/inst_valid SHALL hold their values while stall=1 and jmp=0.
REQ-027 When stall=0 and no instruction is presented, or when jmp=1, outputs SHALL become a bubble: inst=32'h0, inst_valid=0, pc unchanged.
REQ-028 fetch_pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-029 imem_addr SHALL equal fetch_pc in WAIT and the outstanding address in DROP.
REQ-030 Fetch latency SHALL be one cycle from the ack edge to the outputs; there SHALL be no combinational path from imem_rdata to the outputs.

Reset
REQ-031 resetn=0 at a clock edge SHALL set:
- state=IDLE, fetch_pc=RESET_PC, imem_req=0;
- pc=0, inst=0, inst_valid=0;
- buffer and redirect_pc cleared.
REQ-032 Reset SHALL override an outstanding request; a late imem_ack after reset SHALL be ignored until the first new request.

Verification
REQ-033 Reset, then imem_ack=1 every cycle, with rdata=addr^32'hA5A5_0000 -> pc sequence 0,4,8,... and inst_valid=1 from the 3rd cycle after reset release.
REQ-034 Ack at pc=0x10 with exe_stall=1 for 3 cycles -> state HOLD, outputs frozen, imem_req=0; then stall falls -> pc=0x10 presented and next request to 0x14.
REQ-035 jmp=1 with target 0x0000_0103 while a request to 0x20 is outstanding with no ack -> DROP; ack 2 cycles later is discarded; next imem_addr=0x100; no inst_valid for 0x20.
REQ-036 jmp coincident with ack at 0x40 with target 0x200 -> bubble (inst=0, inst_valid=0), next imem_addr=0x200.
REQ-037 RESET_PC=32'hFFFF_FFFC with continuous ack -> pc 0xFFFF_FFFC, then 0x0000_0000.
REQ-038 resetn=0 asserted in DROP -> IDLE, all outputs 0; a stale ack arriving in IDLE produces no output change.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues word-aligned requests to instruction memory and
// presents pc/inst to the IF/ID register, handling stalls, redirects and late acks.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        hazard_stall,
    input  logic        exe_stall,
    input  logic        jmp,
    input  logic [31:0] jmp_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] inst,
    output logic        inst_valid
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        HOLD = 2'b10,
        DROP = 2'b11
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] fetch_pc_reg, fetch_pc_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] inst_reg, inst_next;
    logic        valid_reg, valid_next;
    logic [31:0] buf_pc_reg, buf_pc_next;
    logic [31:0] buf_inst_reg, buf_inst_next;
    logic [31:0] redirect_reg, redirect_next;

    logic        stall;
    logic [31:0] target;

    assign stall  = hazard_stall | exe_stall;
    assign target = jmp_target & 32'hFFFF_FFFC;

    // fetch_pc is not advanced until the outstanding request completes, so it
    // doubles as the outstanding address while in DROP.
    assign imem_req   = (state_reg == WAIT) || (state_reg == DROP);
    assign imem_addr  = fetch_pc_reg;
    assign pc         = pc_reg;
    assign inst       = inst_reg;
    assign inst_valid = valid_reg;

    always_comb begin
        state_next    = state_reg;
        fetch_pc_next = fetch_pc_reg;
        pc_next       = pc_reg;
        inst_next     = inst_reg;
        valid_next    = valid_reg;
        buf_pc_next   = buf_pc_reg;
        buf_inst_next = buf_inst_reg;
        redirect_next = redirect_reg;

        // Default output behaviour: a redirect or an idle non-stalled cycle is a bubble.
        if (jmp || !stall) begin
            inst_next  = 32'h0;
            valid_next = 1'b0;
        end

        case (state_reg)
            IDLE: state_next = WAIT;
            WAIT: begin
                if (imem_ack) begin
                    if (jmp) begin
                        fetch_pc_next = target;
                    end else if (stall) begin
                        buf_pc_next   = fetch_pc_reg;
                        buf_inst_next = imem_rdata;
                        state_next    = HOLD;
                    end else begin
                        pc_next       = fetch_pc_reg;
                        inst_next     = imem_rdata;
                        valid_next    = 1'b1;
                        fetch_pc_next = fetch_pc_reg + 32'd4;
                    end
                end else if (jmp) begin
                    redirect_next = target;
                    state_next    = DROP;
                end
            end
            HOLD: begin
                if (jmp) begin
                    fetch_pc_next = target;
                    state_next    = WAIT;
                end else if (!stall) begin
                    pc_next       = buf_pc_reg;
                    inst_next     = buf_inst_reg;
                    valid_next    = 1'b1;
                    fetch_pc_next = fetch_pc_reg + 32'd4;
                    state_next    = WAIT;
                end
            end
            DROP: begin
                if (imem_ack) begin
                    fetch_pc_next = jmp ? target : redirect_reg;
                    state_next    = WAIT;
                end else if (jmp) begin
                    redirect_next = target;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg    <= IDLE;
            fetch_pc_reg <= RESET_PC;
            pc_reg       <= 32'h0;
            inst_reg     <= 32'h0;
            valid_reg    <= 1'b0;
            buf_pc_reg   <= 32'h0;
            buf_inst_reg <= 32'h0;
            redirect_reg <= 32'h0;
        end else begin
            state_reg    <= state_next;
            fetch_pc_reg <= fetch_pc_next;
            pc_reg       <= pc_next;
            inst_reg     <= inst_next;
            valid_reg    <= valid_next;
            buf_pc_reg   <= buf_pc_next;
            buf_inst_reg <= buf_inst_next;
            redirect_reg <= redirect_next;
        end
    end

endmodule
